dtc_walk_eval: RTL and testbench

Sequential, table-driven decision-tree classifier. It evaluates the same kind of binary decision tree as the hardwired `dtc_*` classifiers, but reads its nodes from a loadable node table. Each cycle it visits one node, starting from the root, until it reaches a leaf. It sits beside the hardwired classifiers as a reprogrammable alternative, and it consumes the node tables the tree generator writes out.

---
 rtl/dtc_walk_eval.sv | 151 +++++++++++++++
 tb/tb_dtc_walk_eval.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dtc_walk_eval.sv
// dtc_walk_eval: decision-tree classifier that walks a loadable node table.
// Each WALK cycle visits one node from the root until a leaf ends the walk.
// A walk also ends with an error on an out-of-range feature or on a runaway
// (cyclic) table.
module dtc_walk_eval #(
    parameter int N_INPUTS = 10,
    parameter int N_NODES  = 16,
    parameter int IDX_W    = 4,
    localparam int NW      = 6 + 2 * IDX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_addr,
    input  logic [NW-1:0]       cfg_data,
    output logic                cfg_ready,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_INPUTS-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_class,
    output logic                out_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WALK = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Reset content of every table entry: a class-0 leaf.
    localparam logic [NW-1:0] LEAF_RST = {1'b1, {(NW-1){1'b0}}};
    // Last legal step count; reaching it on a non-leaf means the table loops.
    localparam logic [IDX_W-1:0] STEP_MAX = IDX_W'(N_NODES - 1);

    state_t              state_q, state_d;
    logic [NW-1:0]       node_q [N_NODES];
    logic [NW-1:0]       node_d [N_NODES];
    logic [IDX_W-1:0]    cur_q, cur_d;
    logic [IDX_W-1:0]    steps_q, steps_d;
    logic [N_INPUTS-1:0] data_q, data_d;
    logic                class_q, class_d;
    logic                err_q, err_d;

    // Fields of the node currently being visited.
    logic [NW-1:0]       node_cur;
    logic                nd_leaf;
    logic                nd_class;
    logic [3:0]          nd_feat;
    logic [IDX_W-1:0]    nd_idx1;
    logic [IDX_W-1:0]    nd_idx0;

    // Handshake outputs decode the registered state only.
    assign in_ready  = (state_q == S_IDLE);
    assign cfg_ready = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_class = class_q;
    assign out_err   = err_q;

    // Split the visited node word into its fields.
    always_comb begin
        node_cur = node_q[cur_q];
        nd_leaf  = node_cur[NW-1];
        nd_class = node_cur[NW-2];
        nd_feat  = node_cur[NW-3 -: 4];
        nd_idx1  = node_cur[2*IDX_W-1 -: IDX_W];
        nd_idx0  = node_cur[IDX_W-1:0];
    end

    // Table write: only accepted while idle, so a walk never sees a torn table.
    always_comb begin
        node_d = node_q;
        if (cfg_we && cfg_ready) begin
            node_d[cfg_addr] = cfg_data;
        end
    end

    // Walk control: accept, step one node per cycle, hold result until taken.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        steps_d = steps_q;
        data_d  = data_q;
        class_d = class_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    cur_d   = '0;
                    steps_d = '0;
                    state_d = S_WALK;
                end
            end
            S_WALK: begin
                if (nd_leaf) begin
                    class_d = nd_class;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (int'(nd_feat) >= N_INPUTS) begin
                    class_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (steps_q == STEP_MAX) begin
                    class_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cur_d   = data_q[nd_feat] ? nd_idx1 : nd_idx0;
                    steps_d = steps_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state, result registers and node table; reset reloads the table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            steps_q <= '0;
            class_q <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < N_NODES; i++) begin
                node_q[i] <= LEAF_RST;
            end
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            steps_q <= steps_d;
            class_q <= class_d;
            err_q   <= err_d;
            node_q  <= node_d;
        end
    end

    // Latched feature vector; only meaningful during a walk, so no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

endmodule

// File: tb/tb_dtc_walk_eval.sv
// Bench for dtc_walk_eval: expected results are queued when a vector is sent
// and compared when the classifier raises out_valid.
module tb_dtc_walk_eval;

    localparam int N_INPUTS = 10;
    localparam int N_NODES  = 16;
    localparam int IDX_W    = 4;
    localparam int NW       = 6 + 2 * IDX_W;

    logic                clk;
    logic                rst;
    logic                cfg_we;
    logic [IDX_W-1:0]    cfg_addr;
    logic [NW-1:0]       cfg_data;
    logic                cfg_ready;
    logic                in_valid;
    logic                in_ready;
    logic [N_INPUTS-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_class;
    logic                out_err;

    typedef struct {
        logic cls;
        logic err;
        int   lat;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    dtc_walk_eval #(
        .N_INPUTS(N_INPUTS),
        .N_NODES (N_NODES),
        .IDX_W   (IDX_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .cfg_ready(cfg_ready),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_class(out_class),
        .out_err  (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [NW-1:0] mk(input logic leaf, input logic cls, input logic [3:0] feat,
                                         input logic [IDX_W-1:0] i1, input logic [IDX_W-1:0] i0);
        return {leaf, cls, feat, i1, i0};
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 32'(in_ready), 1);
    endtask

    task automatic wr(input logic [IDX_W-1:0] a, input logic [NW-1:0] d);
        wait_idle();
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    // Send one vector, then wait (bounded) for its result and score it.
    task automatic send(input logic [N_INPUTS-1:0] v, input logic ec, input logic ee, input int el);
        int   lat;
        exp_t e;
        wait_idle();
        in_valid = 1'b1;
        in_data  = v;
        e.cls = ec;
        e.err = ee;
        e.lat = el;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = N_INPUTS'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        check("out_valid", 32'(out_valid), 1);
        check("latency", lat, e.lat);
        check("out_class", 32'(out_class), 32'(e.cls));
        check("out_err", 32'(out_err), 32'(e.err));
        check("in_ready_busy", 32'(in_ready), 0);
    endtask

    task automatic load_tree();
        wr(4'd0, mk(1'b0, 1'b0, 4'd1, 4'd2, 4'd1));
        wr(4'd1, mk(1'b0, 1'b0, 4'd3, 4'd3, 4'd4));
        wr(4'd2, mk(1'b0, 1'b0, 4'd2, 4'd4, 4'd3));
        wr(4'd3, mk(1'b1, 1'b0, 4'd0, 4'd0, 4'd0));
        wr(4'd4, mk(1'b1, 1'b1, 4'd0, 4'd0, 4'd0));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Asynchronous reset, checked before any clock edge sees it.
        #3 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_class", 32'(out_class), 0);
        check("rst_out_err", 32'(out_err), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_cfg_ready", 32'(cfg_ready), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(10'h000, 1'b0, 1'b0, 1);

        // Depth-2 tree.
        load_tree();
        send(10'h000, 1'b1, 1'b0, 3);
        send(10'h008, 1'b0, 1'b0, 3);
        send(10'h002, 1'b0, 1'b0, 3);
        send(10'h006, 1'b1, 1'b0, 3);

        // Bad feature index at the root.
        wr(4'd0, mk(1'b0, 1'b0, 4'd12, 4'd2, 4'd1));
        send(10'h3FF, 1'b0, 1'b1, 1);

        // Self-loop at the root hits the depth limit.
        wr(4'd0, mk(1'b0, 1'b0, 4'd0, 4'd0, 4'd0));
        send(10'h000, 1'b0, 1'b1, 16);
        send(10'h001, 1'b0, 1'b1, 16);

        // Backpressure: result held, table writes dropped while in DONE.
        wr(4'd0, mk(1'b0, 1'b0, 4'd1, 4'd2, 4'd1));
        out_ready = 1'b0;
        send(10'h008, 1'b0, 1'b0, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cfg_we   = 1'b1;
            cfg_addr = 4'd3;
            cfg_data = mk(1'b1, 1'b1, 4'd0, 4'd0, 4'd0);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_out_class", 32'(out_class), 0);
            check("bp_out_err", 32'(out_err), 0);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_cfg_ready", 32'(cfg_ready), 0);
        end
        @(negedge clk);
        cfg_we    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(10'h008, 1'b0, 1'b0, 3);

        // Reset during WALK: back to IDLE at once and table reloaded.
        wait_idle();
        in_valid = 1'b1;
        in_data  = 10'h000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("walk_in_ready", 32'(in_ready), 0);
        #2 rst = 1'b1;
        #1;
        check("mrst_out_valid", 32'(out_valid), 0);
        check("mrst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        send(10'h000, 1'b0, 1'b0, 1);
        send(10'h3FF, 1'b0, 1'b0, 1);

        // Reset while holding a result in DONE drops it immediately.
        wr(4'd0, mk(1'b1, 1'b1, 4'd0, 4'd0, 4'd0));
        out_ready = 1'b0;
        send(10'h000, 1'b1, 1'b0, 1);
        #2 rst = 1'b1;
        #1;
        check("drst_out_valid", 32'(out_valid), 0);
        check("drst_out_class", 32'(out_class), 0);
        check("drst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        send(10'h000, 1'b0, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
